// File: rtl/tcp_tx_arb_if.sv
// Bundle of the TCP->parser TX header path seen by tcp_tx_arb.
// Requester side: per-source valid, accept and packed header/descriptor slices.
// Parser side: one registered slot with valid/ready.
//
// Handshake: a transfer happens on a rising clk edge where valid and its
// matching ready/accept are both high. A valid source holds val and data
// stable until accepted. Valid must never depend combinationally on the
// accept it is waiting for.
//
// Modports: slave = the arbiter, master = requesters plus parser.

`ifndef IP_HEADER_WIDTH
`define IP_HEADER_WIDTH 160
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif
`ifndef PAYLOAD_BUF_ENTRY_ADDR_WIDTH
`define PAYLOAD_BUF_ENTRY_ADDR_WIDTH 16
`endif
`ifndef PAYLOAD_BUF_ENTRY_LEN_WIDTH
`define PAYLOAD_BUF_ENTRY_LEN_WIDTH 16
`endif

interface tcp_tx_arb_if #(
  parameter int NUM_SRC  = 4,
  parameter int SRC_ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  // requester side
  logic [NUM_SRC-1:0]                                    src_tx_val;
  logic [NUM_SRC-1:0]                                    tx_src_rdy;
  logic [NUM_SRC*`IP_HEADER_WIDTH-1:0]                   src_tx_ip_hdr;
  logic [NUM_SRC*`TCP_HEADER_WIDTH-1:0]                  src_tx_tcp_hdr;
  logic [NUM_SRC*`PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0]      src_tx_payload_addr;
  logic [NUM_SRC*`PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]       src_tx_payload_len;

  // parser side
  logic                                                  tcp_parser_tx_val;
  logic                                                  parser_tx_tcp_rdy;
  logic [`IP_HEADER_WIDTH-1:0]                           tcp_parser_tx_ip_header;
  logic [`TCP_HEADER_WIDTH-1:0]                          tcp_parser_tx_tcp_header;
  logic [`PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0]              tcp_parser_tx_payload_addr;
  logic [`PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]               tcp_parser_tx_payload_len;
  logic [SRC_ID_W-1:0]                                   tcp_parser_tx_src_id;

  modport slave (
    input  src_tx_val, src_tx_ip_hdr, src_tx_tcp_hdr,
           src_tx_payload_addr, src_tx_payload_len, parser_tx_tcp_rdy,
    output tx_src_rdy, tcp_parser_tx_val, tcp_parser_tx_ip_header,
           tcp_parser_tx_tcp_header, tcp_parser_tx_payload_addr,
           tcp_parser_tx_payload_len, tcp_parser_tx_src_id
  );

  modport master (
    output src_tx_val, src_tx_ip_hdr, src_tx_tcp_hdr,
           src_tx_payload_addr, src_tx_payload_len, parser_tx_tcp_rdy,
    input  tx_src_rdy, tcp_parser_tx_val, tcp_parser_tx_ip_header,
           tcp_parser_tx_tcp_header, tcp_parser_tx_payload_addr,
           tcp_parser_tx_payload_len, tcp_parser_tx_src_id
  );
endinterface

// File: rtl/tcp_tx_arb.sv
// tcp_tx_arb: round-robin arbiter sharing the TCP->parser TX header slot
// among NUM_SRC requesters. One registered output slot, 1 packet/cycle,
// 1-cycle accept-to-output latency, refill allowed in the draining cycle.
// Optional macro TCP_TX_ARB_STATS_EN adds per-source 32-bit accept counters
// on tx_arb_pkt_cnt; without it the port is absent and timing is unchanged.

`ifndef IP_HEADER_WIDTH
`define IP_HEADER_WIDTH 160
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif
`ifndef PAYLOAD_BUF_ENTRY_ADDR_WIDTH
`define PAYLOAD_BUF_ENTRY_ADDR_WIDTH 16
`endif
`ifndef PAYLOAD_BUF_ENTRY_LEN_WIDTH
`define PAYLOAD_BUF_ENTRY_LEN_WIDTH 16
`endif

module tcp_tx_arb #(
  parameter int NUM_SRC  = 4,
  parameter int SRC_ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  tcp_tx_arb_if.slave        bus
`ifdef TCP_TX_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0] tx_arb_pkt_cnt
`endif
);

  localparam int IPW  = `IP_HEADER_WIDTH;
  localparam int TCPW = `TCP_HEADER_WIDTH;
  localparam int AW   = `PAYLOAD_BUF_ENTRY_ADDR_WIDTH;
  localparam int LW   = `PAYLOAD_BUF_ENTRY_LEN_WIDTH;

  // slot state
  logic                full_q;
  logic [SRC_ID_W-1:0] rr_ptr_q;
  logic [SRC_ID_W-1:0] src_id_q;
  logic [IPW-1:0]      ip_q;
  logic [TCPW-1:0]     tcp_q;
  logic [AW-1:0]       addr_q;
  logic [LW-1:0]       len_q;

  // arbitration
  logic                load;
  logic                any_val;
  logic                accept;
  logic                found;
  int                  idx;
  logic [SRC_ID_W-1:0] idx_s;
  logic [SRC_ID_W-1:0] grant_id;
  logic [SRC_ID_W-1:0] rr_ptr_nxt;
  logic [NUM_SRC-1:0]  grant_oh;

  // selected source data
  logic [IPW-1:0]      sel_ip;
  logic [TCPW-1:0]     sel_tcp;
  logic [AW-1:0]       sel_addr;
  logic [LW-1:0]       sel_len;

  // Slot can take a new packet when empty or when it drains this cycle.
  assign load    = ~full_q | bus.parser_tx_tcp_rdy;
  assign any_val = |bus.src_tx_val;
  assign accept  = load & any_val;

  // Rotating priority search: first valid source at or after rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    idx      = 0;
    idx_s    = '0;
    grant_id = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_s = SRC_ID_W'(idx);
      if (!found && bus.src_tx_val[idx_s]) begin
        found    = 1'b1;
        grant_id = idx_s;
      end
    end
  end

  // Priority moves just past the granted source; wraps at the last index.
  always_comb begin
    rr_ptr_nxt = '0;
    if (int'(grant_id) != NUM_SRC - 1) rr_ptr_nxt = grant_id + 1'b1;
  end

  // One-hot accept, suppressed while stalled, idle or held in reset.
  always_comb begin
    grant_oh = NUM_SRC'(1) << grant_id;
    bus.tx_src_rdy = (accept && rst_n) ? grant_oh : '0;
  end

  // Datapath mux: slices of the winning source.
  assign sel_ip   = bus.src_tx_ip_hdr[grant_id*IPW +: IPW];
  assign sel_tcp  = bus.src_tx_tcp_hdr[grant_id*TCPW +: TCPW];
  assign sel_addr = bus.src_tx_payload_addr[grant_id*AW +: AW];
  assign sel_len  = bus.src_tx_payload_len[grant_id*LW +: LW];

  // Slot occupancy and round-robin pointer; idle cycles leave priority alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      rr_ptr_q <= '0;
      src_id_q <= '0;
    end else if (accept) begin
      full_q   <= 1'b1;
      rr_ptr_q <= rr_ptr_nxt;
      src_id_q <= grant_id;
    end else if (bus.parser_tx_tcp_rdy) begin
      full_q   <= 1'b0;
    end
  end

  // Slot payload: loaded only on accept, otherwise held (stale after a drain).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q   <= '0;
      tcp_q  <= '0;
      addr_q <= '0;
      len_q  <= '0;
    end else if (accept) begin
      ip_q   <= sel_ip;
      tcp_q  <= sel_tcp;
      addr_q <= sel_addr;
      len_q  <= sel_len;
    end
  end

  assign bus.tcp_parser_tx_val          = full_q;
  assign bus.tcp_parser_tx_ip_header    = ip_q;
  assign bus.tcp_parser_tx_tcp_header   = tcp_q;
  assign bus.tcp_parser_tx_payload_addr = addr_q;
  assign bus.tcp_parser_tx_payload_len  = len_q;
  assign bus.tcp_parser_tx_src_id       = src_id_q;

`ifdef TCP_TX_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [NUM_SRC];

  // Per-source accept counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) pkt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept && grant_id == SRC_ID_W'(i)) pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt_out
    assign tx_arb_pkt_cnt[gi*32 +: 32] = pkt_cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_tcp_tx_arb.sv
// Bench for tcp_tx_arb: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural slot/round-robin model.

`ifndef IP_HEADER_WIDTH
`define IP_HEADER_WIDTH 160
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif
`ifndef PAYLOAD_BUF_ENTRY_ADDR_WIDTH
`define PAYLOAD_BUF_ENTRY_ADDR_WIDTH 16
`endif
`ifndef PAYLOAD_BUF_ENTRY_LEN_WIDTH
`define PAYLOAD_BUF_ENTRY_LEN_WIDTH 16
`endif

module tb_tcp_tx_arb;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int IPW  = `IP_HEADER_WIDTH;
  localparam int TCPW = `TCP_HEADER_WIDTH;
  localparam int AW   = `PAYLOAD_BUF_ENTRY_ADDR_WIDTH;
  localparam int LW   = `PAYLOAD_BUF_ENTRY_LEN_WIDTH;
  localparam int CW   = (IPW > TCPW) ? IPW : TCPW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcp_tx_arb_if #(.NUM_SRC(N), .SRC_ID_W(IDW)) ifc ();
`ifdef TCP_TX_ARB_STATS_EN
  logic [N*32-1:0] pkt_cnt;
`endif

  tcp_tx_arb #(.NUM_SRC(N), .SRC_ID_W(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
`ifdef TCP_TX_ARB_STATS_EN
    ,
    .tx_arb_pkt_cnt (pkt_cnt)
`endif
  );

  // ---------------- source stimulus state ----------------
  logic [N-1:0]    s_val;
  logic            p_rdy;
  logic [IPW-1:0]  s_ip   [N];
  logic [TCPW-1:0] s_tcp  [N];
  logic [AW-1:0]   s_addr [N];
  logic [LW-1:0]   s_len  [N];

  assign ifc.src_tx_val        = s_val;
  assign ifc.parser_tx_tcp_rdy = p_rdy;
  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign ifc.src_tx_ip_hdr[gi*IPW +: IPW]         = s_ip[gi];
    assign ifc.src_tx_tcp_hdr[gi*TCPW +: TCPW]      = s_tcp[gi];
    assign ifc.src_tx_payload_addr[gi*AW +: AW]     = s_addr[gi];
    assign ifc.src_tx_payload_len[gi*LW +: LW]      = s_len[gi];
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic new_data(input int i);
    s_ip[i]   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    s_tcp[i]  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    s_addr[i] = AW'($urandom);
    s_len[i]  = LW'($urandom_range(1, 1500));
  endtask

  // Called just after a negedge: advance one clock, refresh accepted sources.
  task automatic adv();
    logic [N-1:0] acc;
    acc = ifc.tx_src_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) new_data(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural model + compare ----------------
  logic            m_full;
  int              m_ptr;
  int              m_src;
  logic [IPW-1:0]  m_ip;
  logic [TCPW-1:0] m_tcp;
  logic [AW-1:0]   m_addr;
  logic [LW-1:0]   m_len;
  int              m_cnt [N];

  always @(negedge clk) begin
    logic [N-1:0] e_rdy;
    int g;
    int j;
    if (!rst_n) begin
      chk("rst_val", CW'(ifc.tcp_parser_tx_val), '0);
      chk("rst_rdy", CW'(ifc.tx_src_rdy), '0);
      chk("rst_src_id", CW'(ifc.tcp_parser_tx_src_id), '0);
      chk("rst_ip", CW'(ifc.tcp_parser_tx_ip_header), '0);
      m_full = 1'b0;
      m_ptr  = 0;
      m_src  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      e_rdy = '0;
      g = -1;
      if ((!m_full || p_rdy) && s_val != '0) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && s_val[j]) g = j;
        end
        e_rdy[g] = 1'b1;
      end
      chk("tx_src_rdy", CW'(ifc.tx_src_rdy), CW'(e_rdy));
      chk("tx_val", CW'(ifc.tcp_parser_tx_val), CW'(m_full));
      if (m_full) begin
        chk("src_id", CW'(ifc.tcp_parser_tx_src_id), CW'(m_src));
        chk("ip_hdr", CW'(ifc.tcp_parser_tx_ip_header), CW'(m_ip));
        chk("tcp_hdr", CW'(ifc.tcp_parser_tx_tcp_header), CW'(m_tcp));
        chk("addr", CW'(ifc.tcp_parser_tx_payload_addr), CW'(m_addr));
        chk("len", CW'(ifc.tcp_parser_tx_payload_len), CW'(m_len));
      end
`ifdef TCP_TX_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("pkt_cnt", CW'(pkt_cnt[i*32 +: 32]), CW'(m_cnt[i]));
`endif
      if (g >= 0) begin
        m_full = 1'b1;
        m_src  = g;
        m_ip   = s_ip[g];
        m_tcp  = s_tcp[g];
        m_addr = s_addr[g];
        m_len  = s_len[g];
        m_ptr  = (g + 1) % N;
        m_cnt[g] = m_cnt[g] + 1;
      end else if (p_rdy) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  logic [IPW-1:0] rec_ip;
  logic [LW-1:0]  rec_len;
  int exp_seq [7] = '{0, 1, 2, 3, 0, 1, 2};

  initial begin
    for (int i = 0; i < N; i++) new_data(i);
    s_val = 4'b1111;
    p_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy_gated", CW'(ifc.tx_src_rdy), '0);
    chk("reset_val", CW'(ifc.tcp_parser_tx_val), '0);
    @(posedge clk);
    #1;
    s_val = '0;
    rst_n = 1'b1;

    // single source 2, continuously valid, len 64
    s_len[2] = 16'd64;
    s_val = 4'b0100;
    p_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("s2_val", CW'(ifc.tcp_parser_tx_val), CW'(1));
        chk("s2_src_id", CW'(ifc.tcp_parser_tx_src_id), CW'(2));
        chk("s2_ip", CW'(ifc.tcp_parser_tx_ip_header), CW'(rec_ip));
        chk("s2_len", CW'(ifc.tcp_parser_tx_payload_len), CW'(16'd64));
      end
      chk("s2_rdy", CW'(ifc.tx_src_rdy), CW'(4'b0100));
      rec_ip = s_ip[2];
      adv();
      s_len[2] = 16'd64;
    end

    // all four valid from ptr 0: strict rotation
    do_reset();
    s_val = 4'b1111;
    p_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c > 0) chk("rr_seq", CW'(ifc.tcp_parser_tx_src_id), CW'(exp_seq[c-1]));
      chk("rr_onehot", CW'($countones(ifc.tx_src_rdy)), CW'(1));
      adv();
    end

    // stall with slot from src 1, then release grants src 3 in the same cycle
    do_reset();
    s_val = 4'b0010;
    p_rdy = 1'b0;
    @(negedge clk);
    chk("st_fill_rdy", CW'(ifc.tx_src_rdy), CW'(4'b0010));
    rec_ip = s_ip[1];
    adv();
    s_val = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("st_rdy", CW'(ifc.tx_src_rdy), '0);
      chk("st_val", CW'(ifc.tcp_parser_tx_val), CW'(1));
      chk("st_src_id", CW'(ifc.tcp_parser_tx_src_id), CW'(1));
      chk("st_ip", CW'(ifc.tcp_parser_tx_ip_header), CW'(rec_ip));
      adv();
    end
    p_rdy = 1'b1;
    @(negedge clk);
    chk("st_release_rdy", CW'(ifc.tx_src_rdy), CW'(4'b1000));
    adv();
    @(negedge clk);
    chk("st_after_src_id", CW'(ifc.tcp_parser_tx_src_id), CW'(3));
    chk("st_wrap_rdy", CW'(ifc.tx_src_rdy), CW'(4'b0001));
    adv();

    // ptr 3 with only src 0 valid, then src 0 and 1; zero-length forwarded
    do_reset();
    s_val = 4'b0100;
    @(negedge clk);
    adv();
    s_val = 4'b0001;
    @(negedge clk);
    chk("p3_rdy", CW'(ifc.tx_src_rdy), CW'(4'b0001));
    adv();
    s_len[1] = '0;
    s_val = 4'b0011;
    @(negedge clk);
    chk("p1_rdy", CW'(ifc.tx_src_rdy), CW'(4'b0010));
    adv();
    @(negedge clk);
    chk("zlen_src_id", CW'(ifc.tcp_parser_tx_src_id), CW'(1));
    chk("zlen_len", CW'(ifc.tcp_parser_tx_payload_len), '0);
    chk("zlen_val", CW'(ifc.tcp_parser_tx_val), CW'(1));

    // drain with nothing requesting empties the slot
    s_val = '0;
    adv();
    @(negedge clk);
    chk("drain_val", CW'(ifc.tcp_parser_tx_val), '0);
    adv();

    // asynchronous reset with the slot full
    s_val = 4'b1111;
    p_rdy = 1'b0;
    @(negedge clk);
    adv();
    @(negedge clk);
    chk("pre_rst_val", CW'(ifc.tcp_parser_tx_val), CW'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_val", CW'(ifc.tcp_parser_tx_val), '0);
    chk("async_rst_rdy", CW'(ifc.tx_src_rdy), '0);
    @(posedge clk);
    #1;
    s_val = 4'b0110;
    p_rdy = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", CW'(ifc.tx_src_rdy), CW'(4'b0010));
    adv();
    @(negedge clk);
    chk("post_rst_src_id", CW'(ifc.tcp_parser_tx_src_id), CW'(1));
    adv();

`ifdef TCP_TX_ARB_STATS_EN
    // counters: five accepts from src 1, two from src 3
    do_reset();
    s_val = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      adv();
    end
    s_val = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      adv();
    end
    s_val = '0;
    @(negedge clk);
    chk("cnt0", CW'(pkt_cnt[31:0]), '0);
    chk("cnt1", CW'(pkt_cnt[63:32]), CW'(5));
    chk("cnt2", CW'(pkt_cnt[95:64]), '0);
    chk("cnt3", CW'(pkt_cnt[127:96]), CW'(2));
    adv();
`endif

    s_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
